bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 142 ++++++++++++++
 tb/tb_bit_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer
//   Accepts a parallel byte over a valid/ready handshake and streams it out
//   MSB first, one bit per clock, to the downstream run detector. Frames can
//   be chained back to back: a new byte offered in the last cycle of a frame
//   has its MSB on w in the very next cycle.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   din        in   [WIDTH-1:0] parallel byte to transmit
//   din_valid  in   producer offers din this cycle
//   din_ready  out  block accepts din this cycle (transfer = valid & ready)
//   w          out  serial bit stream
//   w_valid    out  w carries a payload or parity bit this cycle
//   busy       out  a frame is in flight
//   frame_cnt  out  [7:0] completed frames, wraps 255 -> 0
//
// Build option
//   PARITY_EN  when defined, every frame gets a ninth cycle carrying even
//              parity over the eight latched bits. Undefined: 8-cycle
//              frames and no parity state or logic.
//
// State table
//   IDLE   | waiting for a byte; ready, no output bit
//   SHIFT  | presenting data_q[idx_q], idx counts 7 down to 0
//   PARITY | presenting XOR of latched bits (PARITY_EN only)

module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int IW = $clog2(WIDTH);

`ifdef PARITY_EN
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  logic [1:0] state_q, state_d;
`else
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic state_q, state_d;
`endif

  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             frame_end;
  logic             xfer;

`ifdef PARITY_EN
  assign frame_end = (state_q == PARITY);
`else
  assign frame_end = (state_q == SHIFT) && (idx_q == '0);
`endif

  // Gated by reset so the producer never sees ready while the block is held.
  assign din_ready = ~reset & ((state_q == IDLE) | frame_end);
  assign xfer      = din_valid & din_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (frame_end) cnt_d = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          data_d  = din;
          idx_d   = IW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          if (xfer) begin
            data_d  = din;
            idx_d   = IW'(WIDTH - 1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (xfer) begin
          data_d  = din;
          idx_d   = IW'(WIDTH - 1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // The byte is held, not shifted; the index selects the bit on the wire.
`ifdef PARITY_EN
  assign w = ((state_q == SHIFT) & data_q[idx_q]) | ((state_q == PARITY) & (^data_q));
`else
  assign w = (state_q == SHIFT) & data_q[idx_q];
`endif

  assign w_valid   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: single byte, back-to-back streaming,
// parity frames (PARITY_EN builds), backpressure, reset mid-frame and
// frame counter wrap. Inputs are driven and outputs sampled 1 ns after
// each rising edge.

module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       w;
  logic       w_valid;
  logic       busy;
  logic [7:0] frame_cnt;

`ifdef PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_cnt  = 8'd0;

  bit_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .w         (w),
    .w_valid   (w_valid),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer byte b in the current (idle) cycle; returns just after the transfer edge.
  task automatic start(input logic [7:0] b);
    check("ready_before_start", din_ready, 1);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Called just after the transfer edge of byte b. Checks every frame cycle.
  // nv/nd: handshake offered in the frame-end cycle; noise: wiggle din and
  // din_valid while the block is not ready.
  task automatic run_frame(input logic [7:0] b, input logic nv, input logic [7:0] nd,
                           input logic noise);
    for (int i = 0; i < FL; i++) begin
      logic expw;
      expw = (i < 8) ? b[7-i] : ^b;
      if (i == FL - 1) begin
        din_valid = nv;
        din       = nd;
      end else if (noise) begin
        din_valid = i[0];
        din       = b ^ 8'(i * 37 + 1);
      end else begin
        din_valid = 1'b0;
      end
      check($sformatf("w[%0d] byte %0h", i, b), w, expw);
      check($sformatf("w_valid[%0d]", i), w_valid, 1);
      check($sformatf("busy[%0d]", i), busy, 1);
      check($sformatf("din_ready[%0d]", i), din_ready, (i == FL - 1) ? 1 : 0);
      tick();
    end
    din_valid = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    check("frame_cnt_after_frame", frame_cnt, exp_cnt);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_w"}, w, 0);
    check({tag, "_w_valid"}, w_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_din_ready"}, din_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    tick();
    tick();
    // While held in reset
    check("rst_din_ready", din_ready, 0);
    check("rst_w", w, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    #1;
    check("rel_din_ready", din_ready, 1);
    tick();

    // Single byte A5: 1,0,1,0,0,1,0,1
    start(8'hA5);
    run_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    check_idle("single_end");
    check("single_cnt", frame_cnt, 8'd1);
    tick();
    check_idle("single_idle2");

    // Back-to-back 00 then FF with no gap
    start(8'h00);
    run_frame(8'h00, 1'b1, 8'hFF, 1'b0);
    run_frame(8'hFF, 1'b0, 8'h00, 1'b0);
    check_idle("b2b_end");
    check("b2b_cnt", frame_cnt, 8'd3);

`ifdef PARITY_EN
    // 07 -> parity 1, 03 -> parity 0, streamed
    start(8'h07);
    run_frame(8'h07, 1'b1, 8'h03, 1'b0);
    run_frame(8'h03, 1'b0, 8'h00, 1'b0);
    check_idle("par_end");
    check("par_cnt", frame_cnt, 8'd5);
`endif

    // Backpressure: din and din_valid wiggle while not ready
    start(8'h3C);
    run_frame(8'h3C, 1'b0, 8'h00, 1'b1);
    check_idle("bp_end");
    tick();
    check_idle("bp_idle2");
    check("bp_cnt", frame_cnt, exp_cnt);

    // Reset at bit 4 of F0
    start(8'hF0);
    tick();
    tick();
    tick();
    check("mid_bit4", w, 1);
    check("mid_bit4_valid", w_valid, 1);
    reset = 1'b1;
    #1;
    check("abort_w", w, 0);
    check("abort_w_valid", w_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", frame_cnt, 0);
    check("abort_ready", din_ready, 0);
    tick();
    tick();
    check("abort_hold_w_valid", w_valid, 0);
    reset = 1'b0;
    #1;
    exp_cnt = 8'd0;
    check_idle("abort_rel");
    tick();
    tick();
    check_idle("abort_after");
    check("abort_cnt_after", frame_cnt, 0);

    // 256 streamed frames: counter returns to 0
    start(8'h00);
    for (int k = 0; k < 256; k++) begin
      run_frame(8'(k), (k < 255) ? 1'b1 : 1'b0, 8'(k + 1), 1'b0);
      if (k == 254) check("wrap_cnt_255", frame_cnt, 8'd255);
    end
    check("wrap_cnt_0", frame_cnt, 8'd0);
    check_idle("wrap_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
